// File: rtl/sram_host_pkg.sv
// Shared types and pin-map constants for the tiny-SRAM host initiator.
// The CHK_* states exist only when SRAM_HOST_RDCHK_EN is defined.
package sram_host_pkg;

    localparam int unsigned ADDR_LSB   = 0;
    localparam int unsigned WE_BIT     = 6;
    localparam int unsigned STB_BIT    = 7;
    localparam int unsigned PIN_ADDR_W = 6;
    localparam logic [7:0]  BUS_DRIVE  = 8'hFF;

`ifdef SRAM_HOST_RDCHK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_RESP,
        ST_CHK_SETUP, ST_CHK_STROBE, ST_CHK_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_RESP
    } state_t;
`endif

    // Assemble the tile ui_in word from address, write enable and strobe.
    function automatic logic [7:0] pin_ui_word(input logic [PIN_ADDR_W-1:0] addr,
                                               input logic we, input logic stb);
        logic [7:0] w;
        w = 8'h00;
        w[ADDR_LSB +: PIN_ADDR_W] = addr;
        w[WE_BIT]  = we;
        w[STB_BIT] = stb;
        return w;
    endfunction

endpackage

// File: rtl/sram_host_ctrl_wait_cnt.sv
// Loadable down-counter timing the read latency after a strobe.
// done is high in the last latency cycle, so the capture edge ends it.
module sram_host_wait_cnt #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Reload on the strobe cycle, then count down to zero and rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_W'(RD_LAT);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/sram_host_ctrl.sv
// Host-side sequencer for the tiny-SRAM tile pins (single read/write per request).
// Optional write readback check: define SRAM_HOST_RDCHK_EN.
module sram_host_ctrl
    import sram_host_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        pin_ui,
    output logic [7:0]        pin_uio,
    output logic [7:0]        pin_uio_oe,
    input  logic [7:0]        pin_uo
);
    if (ADDR_W < 1 || ADDR_W > PIN_ADDR_W) begin : g_bad_addr_w
        $error("sram_host_ctrl: ADDR_W must be in 1..6");
    end
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("sram_host_ctrl: RD_LAT must be in 1..15");
    end

    state_t                state_r;
    logic                  we_r;
    logic [PIN_ADDR_W-1:0] addr_r;
    logic [PIN_ADDR_W-1:0] addr_ext_s;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [7:0]            rsp_rdata_r;
    logic [7:0]            pin_ui_r;
    logic [7:0]            pin_uio_r;
    logic [7:0]            pin_uio_oe_r;
    logic                  load_s;
    logic                  done_s;

    // Zero-extend the request address onto the 6-bit pin field.
    always_comb begin
        addr_ext_s = {PIN_ADDR_W{1'b0}};
        addr_ext_s[ADDR_W-1:0] = req_addr;
    end

    // Latency counter restarts on any strobe cycle (host read or readback).
    always_comb begin
        load_s = (state_r == ST_STROBE);
`ifdef SRAM_HOST_RDCHK_EN
        if (state_r == ST_CHK_STROBE) begin
            load_s = 1'b1;
        end else begin
            load_s = (state_r == ST_STROBE);
        end
`endif
    end

    sram_host_wait_cnt #(.RD_LAT(RD_LAT)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .done  (done_s)
    );

`ifdef SRAM_HOST_RDCHK_EN
    logic [7:0] wdata_r;
    logic       rsp_err_r;
    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

    // Transaction FSM; pin values are loaded on the edge entering each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            addr_r       <= {PIN_ADDR_W{1'b0}};
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 8'h00;
            pin_ui_r     <= 8'h00;
            pin_uio_r    <= 8'h00;
            pin_uio_oe_r <= 8'h00;
`ifdef SRAM_HOST_RDCHK_EN
            wdata_r      <= 8'h00;
            rsp_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r         <= req_we;
                        addr_r       <= addr_ext_s;
                        req_ready_r  <= 1'b0;
                        rsp_rdata_r  <= 8'h00;
                        pin_ui_r     <= pin_ui_word(addr_ext_s, req_we, 1'b0);
                        pin_uio_r    <= req_we ? req_wdata : 8'h00;
                        pin_uio_oe_r <= req_we ? BUS_DRIVE : 8'h00;
`ifdef SRAM_HOST_RDCHK_EN
                        wdata_r      <= req_wdata;
                        rsp_err_r    <= 1'b0;
`endif
                        state_r      <= ST_SETUP;
                    end else begin
                        req_ready_r  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    pin_ui_r <= pin_ui_word(addr_r, we_r, 1'b1);
                    state_r  <= ST_STROBE;
                end
                ST_STROBE: begin
                    pin_ui_r <= pin_ui_word(addr_r, we_r, 1'b0);
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (we_r) begin
                        pin_uio_r    <= 8'h00;
                        pin_uio_oe_r <= 8'h00;
`ifdef SRAM_HOST_RDCHK_EN
                        pin_ui_r     <= pin_ui_word(addr_r, 1'b0, 1'b0);
                        state_r      <= ST_CHK_SETUP;
`else
                        pin_ui_r     <= 8'h00;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_RESP;
`endif
                    end else if (done_s) begin
                        rsp_rdata_r <= pin_uo;
                        pin_ui_r    <= 8'h00;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r     <= ST_WAIT;
                    end
                end
`ifdef SRAM_HOST_RDCHK_EN
                ST_CHK_SETUP: begin
                    pin_ui_r <= pin_ui_word(addr_r, 1'b0, 1'b1);
                    state_r  <= ST_CHK_STROBE;
                end
                ST_CHK_STROBE: begin
                    pin_ui_r <= pin_ui_word(addr_r, 1'b0, 1'b0);
                    state_r  <= ST_CHK_WAIT;
                end
                ST_CHK_WAIT: begin
                    if (done_s) begin
                        rsp_rdata_r <= pin_uo;
                        rsp_err_r   <= (pin_uo != wdata_r);
                        pin_ui_r    <= 8'h00;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r     <= ST_CHK_WAIT;
                    end
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b0;
                    rsp_valid_r  <= 1'b0;
                    pin_ui_r     <= 8'h00;
                    pin_uio_r    <= 8'h00;
                    pin_uio_oe_r <= 8'h00;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign pin_ui     = pin_ui_r;
    assign pin_uio    = pin_uio_r;
    assign pin_uio_oe = pin_uio_oe_r;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Directed bench for sram_host_ctrl with a behavioural RD_LAT=2 tile model.
// Expectations follow SRAM_HOST_RDCHK_EN when the bench is built with it.
module tb_sram_host_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [5:0] req_addr = 6'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_ready = 1'b1;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata, pin_ui, pin_uio, pin_uio_oe, pin_uo;

    logic       v4 = 1'b0;
    logic [3:0] addr4 = 4'h0;
    logic [7:0] uo4 = 8'h5A;
    logic       ready4, rvalid4, err4;
    logic [7:0] rdata4, ui4, uio4, oe4;

    int n_cmp = 0;
    int n_mis = 0;
    int overlap = 0;
    int lat;

    logic [7:0] mem [64];
    logic [7:0] p1 = 8'h00;
    logic [7:0] p2 = 8'h00;
    logic       stuck_b0 = 1'b0;

    always #5 clk = ~clk;

    sram_host_ctrl #(.ADDR_W(6), .RD_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .pin_ui(pin_ui), .pin_uio(pin_uio),
        .pin_uio_oe(pin_uio_oe), .pin_uo(pin_uo)
    );

    sram_host_ctrl #(.ADDR_W(4), .RD_LAT(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(ready4),
        .req_we(1'b0), .req_addr(addr4), .req_wdata(8'h00),
        .rsp_valid(rvalid4), .rsp_ready(1'b1), .rsp_rdata(rdata4),
        .rsp_err(err4), .pin_ui(ui4), .pin_uio(uio4),
        .pin_uio_oe(oe4), .pin_uo(uo4)
    );

    // Tile model: write on strobe; read data visible only in the 2nd cycle after strobe.
    always @(posedge clk) begin
        if (pin_ui[7] && pin_ui[6] && pin_uio_oe == 8'hFF)
            mem[pin_ui[5:0]] <= stuck_b0 ? (pin_uio & 8'hFE) : pin_uio;
        p1 <= (pin_ui[7] && !pin_ui[6]) ? mem[pin_ui[5:0]] : 8'h00;
        p2 <= p1;
    end
    assign pin_uo = p2;

    always @(negedge clk) if (req_ready && rsp_valid) overlap++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, hold it until accepted; returns in cycle A+1.
    task automatic accept(input logic we, input logic [5:0] addr, input logic [7:0] wd);
        int i;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        i = 0;
        while (!req_ready && i < 20) begin
            step();
            i++;
        end
        chk("accept_ready", {15'd0, req_ready}, 16'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Count cycles from A+1 until rsp_valid, bounded.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("rsp_timeout", {15'd0, rsp_valid}, 16'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        step(); step();
        chk("rst_req_ready", {15'd0, req_ready}, 16'd0);
        chk("rst_pin_ui", {8'd0, pin_ui}, 16'h00);
        chk("rst_oe", {8'd0, pin_uio_oe}, 16'h00);
        chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {15'd0, req_ready}, 16'd1);

        // Write 0xA5 to 0x15
        accept(1'b1, 6'h15, 8'hA5);
        chk("wr_a1_ui", {8'd0, pin_ui}, 16'h55);
        chk("wr_a1_oe", {8'd0, pin_uio_oe}, 16'hFF);
        chk("wr_a1_uio", {8'd0, pin_uio}, 16'hA5);
        chk("wr_a1_ready", {15'd0, req_ready}, 16'd0);
        step();
        chk("wr_a2_ui", {8'd0, pin_ui}, 16'hD5);
        chk("wr_a2_oe", {8'd0, pin_uio_oe}, 16'hFF);
        step();
        chk("wr_a3_ui", {8'd0, pin_ui}, 16'h55);
        chk("wr_a3_oe", {8'd0, pin_uio_oe}, 16'hFF);
        chk("wr_a3_rsp", {15'd0, rsp_valid}, 16'd0);
        step();
`ifdef SRAM_HOST_RDCHK_EN
        chk("wr_a4_chk_ui", {8'd0, pin_ui}, 16'h15);
        chk("wr_a4_rsp", {15'd0, rsp_valid}, 16'd0);
        step(); step(); step(); step();
        chk("wr_a8_rsp", {15'd0, rsp_valid}, 16'd1);
        chk("wr_rdata", {8'd0, rsp_rdata}, 16'hA5);
        chk("wr_err", {15'd0, rsp_err}, 16'd0);
`else
        chk("wr_a4_rsp", {15'd0, rsp_valid}, 16'd1);
        chk("wr_rdata", {8'd0, rsp_rdata}, 16'h00);
        chk("wr_err", {15'd0, rsp_err}, 16'd0);
`endif
        chk("wr_resp_ui", {8'd0, pin_ui}, 16'h00);
        chk("wr_resp_oe", {8'd0, pin_uio_oe}, 16'h00);
        step();
        chk("wr_done_rsp", {15'd0, rsp_valid}, 16'd0);
        chk("wr_done_ready", {15'd0, req_ready}, 16'd1);

        // Read back 0x15
        accept(1'b0, 6'h15, 8'h00);
        chk("rd_a1_ui", {8'd0, pin_ui}, 16'h15);
        chk("rd_a1_oe", {8'd0, pin_uio_oe}, 16'h00);
        chk("rd_a1_uio", {8'd0, pin_uio}, 16'h00);
        step();
        chk("rd_a2_ui", {8'd0, pin_ui}, 16'h95);
        chk("rd_a2_oe", {8'd0, pin_uio_oe}, 16'h00);
        step();
        chk("rd_a3_rsp", {15'd0, rsp_valid}, 16'd0);
        chk("rd_a3_oe", {8'd0, pin_uio_oe}, 16'h00);
        step();
        chk("rd_a4_rsp", {15'd0, rsp_valid}, 16'd0);
        step();
        chk("rd_a5_rsp", {15'd0, rsp_valid}, 16'd1);
        chk("rd_a5_rdata", {8'd0, rsp_rdata}, 16'hA5);
        chk("rd_a5_ui", {8'd0, pin_ui}, 16'h00);
        step();

        // Back-to-back with rsp_ready low
        rsp_ready = 1'b0;
        accept(1'b0, 6'h15, 8'h00);
        step(); step(); step(); step();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h20; req_wdata = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_hold_valid", {15'd0, rsp_valid}, 16'd1);
            chk("b2b_hold_rdata", {8'd0, rsp_rdata}, 16'hA5);
            chk("b2b_hold_ready", {15'd0, req_ready}, 16'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("b2b_post_hs_valid", {15'd0, rsp_valid}, 16'd0);
        chk("b2b_post_hs_ready", {15'd0, req_ready}, 16'd1);
        chk("b2b_post_hs_ui", {8'd0, pin_ui}, 16'h00);
        step();
        req_valid = 1'b0;
        chk("b2b_2nd_ui", {8'd0, pin_ui}, 16'h60);
        chk("b2b_2nd_oe", {8'd0, pin_uio_oe}, 16'hFF);
        wait_rsp(lat);
`ifdef SRAM_HOST_RDCHK_EN
        chk("b2b_2nd_lat", 16'(lat), 16'd8);
        chk("b2b_2nd_rdata", {8'd0, rsp_rdata}, 16'h3C);
`else
        chk("b2b_2nd_lat", 16'(lat), 16'd4);
        chk("b2b_2nd_rdata", {8'd0, rsp_rdata}, 16'h00);
`endif
        step();

        // Reset during read WAIT
        accept(1'b0, 6'h15, 8'h00);
        step(); step();
        chk("rst_mid_pre_ui", {8'd0, pin_ui}, 16'h15);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ui", {8'd0, pin_ui}, 16'h00);
        chk("rst_mid_oe", {8'd0, pin_uio_oe}, 16'h00);
        chk("rst_mid_ready", {15'd0, req_ready}, 16'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_mid_rel_ready", {15'd0, req_ready}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rst_mid_no_rsp", {15'd0, rsp_valid}, 16'd0);
            step();
        end

        // ADDR_W=4 instance, read 0xF
        v4 = 1'b1; addr4 = 4'hF;
        chk("w4_ready", {15'd0, ready4}, 16'd1);
        step();
        v4 = 1'b0;
        chk("w4_a1_ui", {8'd0, ui4}, 16'h0F);
        step();
        chk("w4_a2_ui", {8'd0, ui4}, 16'h8F);
        step(); step(); step();
        chk("w4_a5_rsp", {15'd0, rvalid4}, 16'd1);
        chk("w4_a5_rdata", {8'd0, rdata4}, 16'h5A);

        // Stuck-at-0 bit 0 tile, write 0x01 to addr 3
        stuck_b0 = 1'b1;
        accept(1'b1, 6'h03, 8'h01);
        wait_rsp(lat);
`ifdef SRAM_HOST_RDCHK_EN
        chk("stuck_lat", 16'(lat), 16'd8);
        chk("stuck_err", {15'd0, rsp_err}, 16'd1);
`else
        chk("stuck_lat", 16'(lat), 16'd4);
        chk("stuck_err", {15'd0, rsp_err}, 16'd0);
`endif
        chk("stuck_rdata", {8'd0, rsp_rdata}, 16'h00);
        step();

        chk("ready_rsp_overlap", 16'(overlap), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_host_ctrl.md
# sram_host_ctrl

Host-side initiator for the tiny-SRAM tile pin protocol: accepts single read/write requests on a valid/ready port and sequences the tile's dedicated-input, bidirectional-IO and output pins to perform them. It is the other end of the tile interface; it sits in the host/FPGA harness and in the bench, and drives the SRAM tile's `ui_in`, `uio_in` and `uo_out` pins directly.

## Interface
- `ADDR_W`, 6: request address width. Legal range 1..6; elaboration error otherwise.
- `RD_LAT`, 2: cycles from strobe to valid read data on `pin_uo`. Legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  8  read data; 0 for writes.
- `rsp_err`  out  1  readback mismatch; only with `SRAM_HOST_RDCHK_EN`, else tied 0.
- `pin_ui`  out  8  to tile `ui_in`: [5:0] address, [6] write enable, [7] strobe.
- `pin_uio`  out  8  to tile `uio_in`: write data.
- `pin_uio_oe`  out  8  host bus drive enable: 0xFF while driving write data, 0x00 otherwise.
- `pin_uo`  in  8  from tile `uo_out`: read data.

## Operation
- States: IDLE, SETUP, STROBE, WAIT, RESP, plus CHK_SETUP, CHK_STROBE, CHK_WAIT when the checker is compiled in.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, the controller latches we, addr and wdata and moves to SETUP.
- SETUP: `pin_ui[5:0]`=addr zero-extended to 6 bits, `pin_ui[6]`=we, `pin_ui[7]`=0. Write: `pin_uio`=wdata, `pin_uio_oe`=0xFF. Read: `pin_uio`=0, `pin_uio_oe`=0x00. Next state is STROBE.
- STROBE: same as SETUP but with `pin_ui[7]`=1 for exactly one cycle. Next state is WAIT.
- WAIT:
  - Write: one hold cycle with strobe 0, address, we and data unchanged, then RESP.
  - Read: count RD_LAT cycles, capture `pin_uo` at the clock edge that ends the RD_LAT-th cycle after STROBE, then RESP.
- RESP: `rsp_valid`=1 with `rsp_rdata` stable. Pins return to idle values: `pin_ui`=0, `pin_uio`=0, `pin_uio_oe`=0. When `rsp_ready` is high, the next state is IDLE.
- `rsp_valid` and `req_ready` are never high in the same cycle. A request presented during a busy cycle is not accepted and must be held by the requester.
- Every output is registered; no combinational path from any input to any output.
- The bus is never driven (`pin_uio_oe`=0) during a read, or in any cycle where the strobe is 1 for a read.

## Timing
- Reset values: `req_ready`=0 while `rst_n`=0 and 1 in the first cycle after release. All other outputs are 0, including `pin_uio_oe`=0x00.
- Reset asserted mid-transaction aborts it immediately and asynchronously: pins go to 0, the bus is released, and no response is issued.
- Cycle numbering: acceptance edge = cycle A. SETUP = A+1. STROBE = A+2.
- Write: hold = A+3; `rsp_valid` from A+4. Latency is 4 cycles to response.
- Read: data is sampled at the end of cycle A+2+RD_LAT; `rsp_valid` from A+3+RD_LAT. With default RD_LAT this is A+5.
- Back-to-back: the earliest next acceptance is the cycle after the `rsp_valid && rsp_ready` edge.

## Configuration
- `SRAM_HOST_RDCHK_EN` defined:
  - After a write's hold cycle, the controller issues an internal read of the same address through CHK_SETUP, CHK_STROBE and CHK_WAIT, with the same timing as a host read.
  - `rsp_err`=1 if the captured byte differs from wdata.
  - `rsp_rdata` = the captured byte.
  - Write latency grows by 2+RD_LAT cycles.
- `SRAM_HOST_RDCHK_EN` not defined: the CHK states do not exist, `rsp_err` is constant 0, and writes return `rsp_rdata`=0.

## Structure
- Package `sram_host_pkg` holds:
  - the state enum;
  - pin bit-position constants (ADDR_LSB=0, WE_BIT=6, STB_BIT=7);
  - `PIN_ADDR_W`=6;
  - `BUS_DRIVE`=8'hFF.
- One sub-module, `sram_host_wait_cnt`: a loadable down-counter of width $clog2(RD_LAT+1) with a `done` pulse. It is shared by WAIT and CHK_WAIT.

## Test plan
- Reset mid-read (assert `rst_n` low in WAIT) → `pin_ui`=0 and `pin_uio_oe`=0 within the same cycle; no `rsp_valid`; `req_ready`=1 one cycle after release.
- Write addr 0x15, data 0xA5 → `pin_ui` = 0x55 in cycle A+1, 0xD5 in A+2, 0x55 in A+3; `pin_uio_oe`=0xFF in A+1..A+3; `rsp_valid` at A+4 (checker off).
- Read addr 0x15 after that write, using a behavioural tile model with RD_LAT=2 → `pin_uio_oe` stays 0x00; `rsp_rdata`=0xA5 at A+5.
- Back-to-back requests with `rsp_ready` held low for 3 cycles → response held stable; second request accepted only after the response handshake; no overlap of `req_ready` and `rsp_valid`.
- ADDR_W=4, read addr 0xF → `pin_ui[5:0]`=0x0F, upper address bits 0.
- `SRAM_HOST_RDCHK_EN` with the tile model forcing bit 0 stuck-at-0, write 0x01 to addr 3 → `rsp_err`=1, `rsp_rdata`=0x00, response at A+8 (RD_LAT=2).
